// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: issues four byte reads per instruction to a
// synchronous byte ROM and presents the little-endian word over valid/ready.
module instr_fetch_seq #(
  parameter int                         ADDRESS_WIDTH = 8,
  parameter int                         DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic                     mem_rd_en_o,
  input  logic [7:0]               mem_data_i,
  input  logic                     redirect_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
  output logic [DATA_WIDTH-1:0]    instr_o,
  output logic [ADDRESS_WIDTH-1:0] pc_o,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  output logic                     busy_o
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int LANE_W    = $clog2(NUM_LANES);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, VALID} state_t;

  state_t                         state;
  logic [ADDRESS_WIDTH-1:0]       pc;
  logic [LANE_W-1:0]              cnt;
  logic                           cap_vld;
  logic [LANE_W-1:0]              cap_lane;
  logic [NUM_LANES-1:0][7:0]      asm_q;
  logic [NUM_LANES-1:0][7:0]      asm_next;

  // Returning byte merged into its lane; DRAIN loads instr_o from this so
  // lane 3 lands in the same edge it is captured.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign asm_next[k] = (cap_vld && cap_lane == LANE_W'(k)) ? mem_data_i : asm_q[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) asm_q <= '0;
    else        asm_q <= asm_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      cnt      <= '0;
      cap_vld  <= 1'b0;
      cap_lane <= '0;
      instr_o  <= '0;
    end else begin
      cap_vld  <= (state == FETCH) && !redirect_i;
      cap_lane <= cnt;
      if (redirect_i) begin
        // Abandon any partial fetch; the in-flight byte is dropped via cap_vld.
        pc    <= redirect_pc_i;
        cnt   <= '0;
        state <= FETCH;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            state <= FETCH;
          end
          FETCH: begin
            cnt <= cnt + 1'b1;
            if (cnt == LANE_W'(NUM_LANES - 1)) state <= DRAIN;
          end
          DRAIN: begin
            instr_o <= asm_next;
            state   <= VALID;
          end
          VALID: begin
            if (instr_ready_i) begin
              pc    <= pc + ADDRESS_WIDTH'(NUM_LANES);
              cnt   <= '0;
              state <= FETCH;
            end
          end
        endcase
      end
    end
  end

  assign mem_rd_en_o   = (state == FETCH);
  assign mem_addr_o    = pc + ADDRESS_WIDTH'(cnt);
  assign pc_o          = pc;
  assign instr_valid_o = (state == VALID);
  assign busy_o        = (state == FETCH) || (state == DRAIN);

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: directed vector table, async reset check, and
// randomized ready/redirect traffic against a fetch-timeline reference model.
module tb_instr_fetch_seq;
  logic        clk;
  logic        rst_n;
  logic [7:0]  mem_addr_o;
  logic        mem_rd_en_o;
  logic [7:0]  mem_data_i;
  logic        redirect_i;
  logic [7:0]  redirect_pc_i;
  logic [31:0] instr_o;
  logic [7:0]  pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  logic [7:0] rom [256];

  instr_fetch_seq #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr_o(mem_addr_o), .mem_rd_en_o(mem_rd_en_o),
    .mem_data_i(mem_data_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_o(instr_o), .pc_o(pc_o), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous byte ROM; garbage on the bus when no read was issued.
  always @(posedge clk) mem_data_i <= mem_rd_en_o ? rom[mem_addr_o] : 8'($urandom);

  typedef struct {
    logic        rdy;
    logic        rdr;
    logic [7:0]  rpc;
    logic        e_rd;
    logic [7:0]  e_addr;
    logic        e_vld;
    logic        e_busy;
    logic        ci;
    logic [31:0] e_instr;
    logic [7:0]  e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rdy, logic rdr, logic [7:0] rpc, logic e_rd,
                              logic [7:0] e_addr, logic e_vld, logic e_busy,
                              logic ci, logic [31:0] e_instr, logic [7:0] e_pc);
    vec_t v;
    v.rdy = rdy; v.rdr = rdr; v.rpc = rpc; v.e_rd = e_rd; v.e_addr = e_addr;
    v.e_vld = e_vld; v.e_busy = e_busy; v.ci = ci; v.e_instr = e_instr; v.e_pc = e_pc;
    return v;
  endfunction

  function automatic logic [31:0] word(logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1; a2 = a + 8'd2; a3 = a + 8'd3;
    return {rom[a3], rom[a2], rom[a1], rom[a]};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply_vec(vec_t v, int idx);
    instr_ready_i = v.rdy;
    redirect_i    = v.rdr;
    redirect_pc_i = v.rpc;
    @(posedge clk); #1;
    chk($sformatf("vec%0d rd_en", idx), mem_rd_en_o, v.e_rd);
    if (v.e_rd) chk($sformatf("vec%0d addr", idx), mem_addr_o, v.e_addr);
    chk($sformatf("vec%0d valid", idx), instr_valid_o, v.e_vld);
    chk($sformatf("vec%0d busy", idx), busy_o, v.e_busy);
    if (v.ci) begin
      chk($sformatf("vec%0d instr", idx), instr_o, v.e_instr);
      chk($sformatf("vec%0d pc", idx), pc_o, v.e_pc);
    end
  endtask

  task automatic chk_reset_outs(string nm);
    chk({nm, " rd_en"}, mem_rd_en_o, 1'b0);
    chk({nm, " addr"}, mem_addr_o, 8'h00);
    chk({nm, " valid"}, instr_valid_o, 1'b0);
    chk({nm, " busy"}, busy_o, 1'b0);
    chk({nm, " instr"}, instr_o, 32'h0);
    chk({nm, " pc"}, pc_o, 8'h00);
  endtask

  initial begin
    logic [7:0] m_pc;
    logic [7:0] ea;
    int         m_t;
    logic       rdy, rdr, m_vld, e_rd;
    logic [7:0] rpc;

    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    {rom[3], rom[2], rom[1], rom[0]}          = 32'h00000013;
    {rom[7], rom[6], rom[5], rom[4]}          = 32'h00100093;
    {rom[11], rom[10], rom[9], rom[8]}        = 32'h44332211;
    {rom[8'h43], rom[8'h42], rom[8'h41], rom[8'h40]} = 32'hefbeadde;
    rom[8'hFE] = 8'haa; rom[8'hFF] = 8'hbb;

    // First fetch then 10 cycles of backpressure in VALID.
    for (int k = 0; k < 4; k++) vecs.push_back(mk(0, 0, 0, 1, 8'(k), 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    for (int k = 0; k < 10; k++) vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 32'h00000013, 8'h00));
    // Streaming with ready high.
    for (int k = 0; k < 4; k++) vecs.push_back(mk(1, 0, 0, 1, 8'(4 + k), 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 32'h00100093, 8'h04));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(1, 0, 0, 1, 8'(8 + k), 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 32'h44332211, 8'h08));
    // Redirect during handshake with address wrap.
    vecs.push_back(mk(1, 1, 8'hFE, 1, 8'hFE, 0, 1, 0, 0, 0));
    for (int k = 1; k < 4; k++) vecs.push_back(mk(1, 0, 0, 1, 8'(8'hFE + k), 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 32'h0013bbaa, 8'hFE));
    // Next fetch at 0x02, redirected to 0x40 while issue_cnt=2.
    for (int k = 0; k < 3; k++) vecs.push_back(mk(1, 0, 0, 1, 8'(2 + k), 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h40, 1, 8'h40, 0, 1, 0, 0, 0));
    for (int k = 1; k < 4; k++) vecs.push_back(mk(0, 0, 0, 1, 8'(8'h40 + k), 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 32'hefbeadde, 8'h40));

    rst_n = 1'b0; instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) apply_vec(vecs[i], i);

    // Asynchronous reset in the middle of a fetch.
    apply_vec(mk(1, 0, 0, 1, 8'h44, 0, 1, 0, 0, 0), 100);
    apply_vec(mk(0, 0, 0, 1, 8'h45, 0, 1, 0, 0, 0), 101);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("async_rst");
    @(posedge clk); #1;
    chk_reset_outs("async_rst_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) apply_vec(vecs[i], 200 + i);

    // Randomized traffic against a timeline model: m_t counts cycles since
    // the fetch started (-1 = idle after reset), reads at 0..3, valid from 5.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_pc = 8'h00; m_t = -1;
    for (int c = 0; c < 3000; c++) begin
      rdy = 1'($urandom_range(0, 1));
      rdr = ($urandom_range(0, 15) == 0);
      rpc = 8'($urandom);
      m_vld = (m_t >= 5);
      if (rdr) begin m_pc = rpc; m_t = 0; end
      else if (m_t < 0) m_t = 0;
      else if (m_vld && rdy) begin m_pc = m_pc + 8'd4; m_t = 0; end
      else if (m_t < 5) m_t++;
      instr_ready_i = rdy; redirect_i = rdr; redirect_pc_i = rpc;
      @(posedge clk); #1;
      e_rd = (m_t >= 0 && m_t < 4);
      chk("rnd rd_en", mem_rd_en_o, e_rd);
      if (e_rd) begin
        ea = m_pc + 8'(m_t);
        chk("rnd addr", mem_addr_o, ea);
      end
      chk("rnd valid", instr_valid_o, m_t >= 5);
      chk("rnd busy", busy_o, m_t >= 0 && m_t < 5);
      if (m_t >= 5) begin
        chk("rnd instr", instr_o, word(m_pc));
        chk("rnd pc", pc_o, m_pc);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
